upsample_interp: RTL and testbench



---
 rtl/pingjun_pkg.sv | 16 +
 rtl/seq_div_const.sv | 60 ++++++
 rtl/upsample_interp.sv | 180 ++++++++++++++++++
 tb/tb_upsample_interp.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pingjun_pkg.sv
// Constants and FSM encoding shared by the block averager and the upsampling interpolator.
// Both ends of the decimate/interpolate path take RATIO from this package, so it cannot drift.
package pingjun_pkg;

  localparam int DATA_W = 8;
  localparam int RATIO  = 53;
  localparam int CNT_W  = 6;
  localparam int REM_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_const.sv
// Restoring unsigned divider by a constant: one quotient bit per clock.
// o_done is high for one cycle, DW clocks after the i_start edge.
module seq_div_const
  import pingjun_pkg::*;
#(
  parameter int DW      = DATA_W,
  parameter int DIVISOR = RATIO,
  parameter int RW      = REM_W,
  parameter int CW      = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  output logic          o_done,
  output logic [DW-1:0] o_q,
  output logic [RW-1:0] o_r
);

  logic [DW-1:0] r_quo;
  logic [RW-1:0] r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [RW:0]   w_shift;
  logic          w_ge;
  logic [RW-1:0] w_rem_next;

  // r_rem is always below DIVISOR, so shifting in one dividend bit fits in RW+1 bits.
  assign w_shift    = {r_rem, r_quo[DW-1]};
  assign w_ge       = (w_shift >= (RW+1)'(DIVISOR));
  assign w_rem_next = w_ge ? RW'(w_shift - (RW+1)'(DIVISOR)) : w_shift[RW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_cnt  <= CW'(DW);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_quo <= {r_quo[DW-2:0], w_ge};
        r_rem <= w_rem_next;
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done = r_busy && (r_cnt == '0);
  assign o_q    = r_quo;
  assign o_r    = r_rem;

endmodule

// File: rtl/upsample_interp.sv
// Rebuilds a dense stream of RATIO linearly interpolated samples per sparse input sample,
// stepping from the previous accepted sample to the current one with an error accumulator.
module upsample_interp
  import pingjun_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_data_de,
  input  logic [DATA_W-1:0] data_in,
  output logic              o_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              o_data_de,
  output logic              o_drop,
  output state_t            o_dbg_state
);

  // Handshake: a sample is taken on any edge where i_data_de && o_ready; a sample
  // offered with o_ready low is discarded and flagged by o_drop on the next cycle.

  state_t r_state, w_state_next;

  logic              r_primed;
  logic [DATA_W-1:0] r_prev;
  logic [DATA_W-1:0] r_cur;
  logic [DATA_W-1:0] r_pend;
  logic              r_pend_valid;
  logic              r_neg;
  logic [DATA_W-1:0] r_acc;
  logic [REM_W-1:0]  r_err;
  logic [CNT_W-1:0]  r_k;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_de;
  logic              r_drop;

  logic              w_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_next_valid;
  logic [DATA_W-1:0] w_next_sample;
  logic              w_start_idle;
  logic              w_start_chain;
  logic              w_div_start;
  logic [DATA_W-1:0] w_base;
  logic [DATA_W-1:0] w_new;
  logic [DATA_W:0]   w_delta;
  logic [DATA_W:0]   w_delta_neg;
  logic              w_neg;
  logic [DATA_W-1:0] w_abs;
  logic              w_div_done;
  logic [DATA_W-1:0] w_div_q;
  logic [REM_W-1:0]  w_div_r;
  logic [REM_W:0]    w_err_sum;
  logic              w_carry;
  logic [REM_W-1:0]  w_err_next;
  logic [DATA_W-1:0] w_step;
  logic [DATA_W-1:0] w_acc_next;

  assign w_ready       = (r_state == IDLE) || !r_pend_valid;
  assign w_accept      = i_data_de && w_ready;
  assign w_last        = (r_state == RUN) && (r_k == CNT_W'(RATIO - 1));
  assign w_next_valid  = r_pend_valid || w_accept;
  assign w_next_sample = r_pend_valid ? r_pend : data_in;
  assign w_start_idle  = (r_state == IDLE) && w_accept && r_primed;
  assign w_start_chain = w_last && w_next_valid;
  assign w_div_start   = w_start_idle || w_start_chain;

  // When chaining, the segment just finished ends at r_cur, which becomes the new prev.
  assign w_base      = (r_state == RUN) ? r_cur : r_prev;
  assign w_new       = w_start_chain ? w_next_sample : data_in;
  assign w_delta     = {1'b0, w_new} - {1'b0, w_base};
  assign w_delta_neg = -w_delta;
  assign w_neg       = w_delta[DATA_W];
  assign w_abs       = w_neg ? w_delta_neg[DATA_W-1:0] : w_delta[DATA_W-1:0];

  seq_div_const #(
    .DW      (DATA_W),
    .DIVISOR (RATIO),
    .RW      (REM_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_abs),
    .o_done     (w_div_done),
    .o_q        (w_div_q),
    .o_r        (w_div_r)
  );

  // Bresenham-style step: q every output plus one extra whenever the remainder wraps.
  assign w_err_sum  = {1'b0, r_err} + {1'b0, w_div_r};
  assign w_carry    = (w_err_sum >= (REM_W+1)'(RATIO));
  assign w_err_next = w_carry ? REM_W'(w_err_sum - (REM_W+1)'(RATIO)) : w_err_sum[REM_W-1:0];
  assign w_step     = w_div_q + DATA_W'(w_carry);
  assign w_acc_next = r_neg ? (r_acc - w_step) : (r_acc + w_step);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_idle) w_state_next = DIV;
      DIV:     if (w_div_done) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = w_next_valid ? DIV : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_primed     <= 1'b0;
      r_prev       <= '0;
      r_cur        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_neg        <= 1'b0;
      r_acc        <= '0;
      r_err        <= '0;
      r_k          <= '0;
      r_data_out   <= '0;
      r_data_de    <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_drop    <= i_data_de && !w_ready;
      r_data_de <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (r_primed) begin
              r_cur <= data_in;
              r_neg <= w_neg;
            end else begin
              r_prev   <= data_in;
              r_primed <= 1'b1;
            end
          end
        end
        DIV: begin
          if (w_accept) begin
            r_pend       <= data_in;
            r_pend_valid <= 1'b1;
          end
          if (w_div_done) begin
            r_acc <= r_prev;
            r_err <= '0;
            r_k   <= '0;
          end
        end
        RUN: begin
          r_acc      <= w_acc_next;
          r_err      <= w_err_next;
          r_k        <= r_k + CNT_W'(1);
          r_data_out <= w_acc_next;
          r_data_de  <= 1'b1;
          if (w_last) begin
            r_prev <= r_cur;
            if (w_next_valid) begin
              r_cur        <= w_next_sample;
              r_neg        <= w_neg;
              r_pend_valid <= 1'b0;
            end
          end else if (w_accept) begin
            r_pend       <= data_in;
            r_pend_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready     = w_ready;
  assign data_out    = r_data_out;
  assign o_data_de   = r_data_de;
  assign o_drop      = r_drop;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_upsample_interp.sv
// Directed bench for upsample_interp: priming, rising/falling/flat segments, full-scale ramp,
// pending capture with drop, back-to-back chaining and asynchronous reset mid-segment.
module tb_upsample_interp;
  import pingjun_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              i_data_de;
  logic [DATA_W-1:0] data_in;
  logic              o_ready;
  logic [DATA_W-1:0] data_out;
  logic              o_data_de;
  logic              o_drop;
  state_t            o_dbg_state;

  int n_pass;
  int n_total;

  upsample_interp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data_de   (i_data_de),
    .data_in     (data_in),
    .o_ready     (o_ready),
    .data_out    (data_out),
    .o_data_de   (o_data_de),
    .o_drop      (o_drop),
    .o_dbg_state (o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Holds reset for three clocks, releases it at a falling edge.
  task automatic do_reset();
    i_data_de = 1'b0;
    data_in   = '0;
    rst_n     = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Offers one sample for one clock; returns at the falling edge after the accepting edge.
  task automatic send(input int v);
    @(negedge clk);
    i_data_de = 1'b1;
    data_in   = DATA_W'(v);
    @(negedge clk);
    i_data_de = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (o_data_de === 1'b1) seen++;
    end
    check(tag, seen, 0);
  endtask

  function automatic int interp(input int p, input int c, input int k);
    int d;
    d = c - p;
    if (d >= 0) return p + (d * k) / RATIO;
    else        return p - ((-d) * k) / RATIO;
  endfunction

  // Waits for the segment prev->cur, checks latency and every sample up to stop_k.
  // Optionally injects two inputs at given output indices and checks ready/drop around them.
  task automatic run_segment(input int p, input int c, input int stop_k,
                             input int inj_k, input int inj_v,
                             input int inj2_k, input int inj2_v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_data_de !== 1'b1 && n < 40);
    check($sformatf("latency %0d->%0d", p, c), n, 10);
    if (o_data_de !== 1'b1) return;
    for (int k = 1; k <= stop_k; k++) begin
      if (k > 1) @(negedge clk);
      i_data_de = 1'b0;
      check($sformatf("seg %0d->%0d k=%0d", p, c, k), data_out, interp(p, c, k));
      if (k == inj_k) begin
        check("ready before pending", o_ready, 1);
        i_data_de = 1'b1;
        data_in   = DATA_W'(inj_v);
      end
      if (inj_k > 0 && k == inj_k + 1) check("ready with pending full", o_ready, 0);
      if (k == inj2_k) begin
        check("ready before drop", o_ready, 0);
        i_data_de = 1'b1;
        data_in   = DATA_W'(inj2_v);
      end
      if (inj2_k > 0 && k == inj2_k + 1) check("drop pulse", o_drop, 1);
      if (inj2_k > 0 && k == inj2_k + 2) check("drop one cycle", o_drop, 0);
    end
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b1;
    i_data_de = 1'b0;
    data_in   = '0;

    // 1: reset values, then a lone sample only primes
    do_reset();
    check("reset data_out", data_out, 0);
    check("reset o_data_de", o_data_de, 0);
    check("reset o_ready", o_ready, 1);
    check("reset o_drop", o_drop, 0);
    check("reset state", o_dbg_state, IDLE);
    send(100);
    expect_quiet("prime only", 20);

    // 2: 0 -> 53 gives 1..53 after 10 clocks
    do_reset();
    send(0);
    send(53);
    run_segment(0, 53, RATIO, 0, 0, 0, 0);
    check("seg2 end value", data_out, 53);
    expect_quiet("seg2 after", 3);

    // 3: falling segment, then a flat one
    do_reset();
    send(200);
    send(94);
    run_segment(200, 94, RATIO, 0, 0, 0, 0);
    expect_quiet("seg3 after", 3);
    send(94);
    run_segment(94, 94, RATIO, 0, 0, 0, 0);
    expect_quiet("flat after", 3);

    // 4: full-scale ramp
    do_reset();
    send(0);
    send(255);
    run_segment(0, 255, RATIO, 0, 0, 0, 0);
    check("ramp end value", data_out, 255);
    expect_quiet("ramp after", 3);

    // 5: pending capture, drop, back-to-back chain
    do_reset();
    send(10);
    send(63);
    run_segment(10, 63, RATIO, 5, 116, 10, 200);
    run_segment(63, 116, RATIO, 0, 0, 0, 0);
    expect_quiet("dropped sample never played", 30);
    check("idle after chain", o_dbg_state, IDLE);

    // 6: asynchronous reset in the middle of a segment
    do_reset();
    send(0);
    send(53);
    run_segment(0, 53, 20, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    #1;
    check("async reset o_data_de", o_data_de, 0);
    check("async reset data_out", data_out, 0);
    check("async reset o_ready", o_ready, 1);
    check("async reset state", o_dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b0;
    send(7);
    expect_quiet("reprime after reset", 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
